wb_timer: RTL

- Wishbone pipelined responder: a 32-bit timer/compare peripheral on the CPU data bus in the IO region (base 0xc0000000).
- The SoC address decoder drives i_enable when signal_address[31:16] == 16'hc000.
- Shares the read-data, ack and stall nets with the memories, so it drives them only when it owns the transfer.
- Provides a free-running or one-shot counter, a compare match flag and a level interrupt.

---
 rtl/wb_timer_pkg.sv | 23 ++
 rtl/wb_timer_prescaler.sv | 31 +++
 rtl/wb_timer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_timer_pkg.sv
// rtl/wb_timer_pkg.sv - register offsets and bit positions shared by the wb_timer block
package wb_timer_pkg;

  // Word offsets on i_addr
  typedef enum logic [2:0] {
    ADDR_CTRL    = 3'd0,
    ADDR_COUNT   = 3'd1,
    ADDR_COMPARE = 3'd2,
    ADDR_STATUS  = 3'd3,
    ADDR_CAPTURE = 3'd4
  } reg_addr_e;

  // CTRL bit indices
  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQEN      = 2;
  localparam int CTRL_W          = 3;

  // STATUS bit indices
  localparam int ST_MATCH = 0;
  localparam int ST_CAPF  = 1;

endpackage

// File: rtl/wb_timer_prescaler.sv
// rtl/wb_timer_prescaler.sv - divides clk into counter ticks, one tick per PRESCALE enabled cycles
module wb_timer_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // The tick is the wrap cycle; a clear in that cycle still lets the tick through
  assign tick = enable & (cnt == LAST);

  // Count 0..PRESCALE-1 while enabled, hold while disabled, restart on clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone pipelined timer/compare peripheral; capture input enabled by WB_TIMER_CAPTURE_EN
module wb_timer #(
  parameter int          PRESCALE      = 1,
  parameter logic [31:0] RESET_COMPARE = 32'hffffffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_we,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_data,
`ifdef WB_TIMER_CAPTURE_EN
  input  logic        i_capture,
`endif
  output logic [31:0] o_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic        o_irq
);

  import wb_timer_pkg::*;

  logic              accept;
  logic              wr_acc;
  logic              wr_ctrl;
  logic              wr_count;
  logic              wr_compare;
  logic              wr_status;
  logic [CTRL_W-1:0] ctrl;
  logic [31:0]       count;
  logic [31:0]       compare;
  logic [31:0]       capture;
  logic              match;
  logic              capf;
  logic              tick;
  logic              hit;
  logic              ack_q;
  logic              irq_q;
  logic [31:0]       rdata_q;
  logic [31:0]       rd_mux;

  // Never stalls: one request per cycle, back-to-back
  assign o_wb_stall = 1'b0;

  assign accept     = i_enable & i_wb_cyc & i_wb_stb;
  assign wr_acc     = accept & i_we;
  assign wr_ctrl    = wr_acc && (i_addr == ADDR_CTRL);
  assign wr_count   = wr_acc && (i_addr == ADDR_COUNT);
  assign wr_compare = wr_acc && (i_addr == ADDR_COMPARE);
  assign wr_status  = wr_acc && (i_addr == ADDR_STATUS);

  // Match check uses COUNT before any increment this tick
  assign hit = tick & (count == compare);

  wb_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (ctrl[CTRL_EN]),
    .clear  (wr_count),
    .tick   (tick)
  );

  // Register read mux, sampled on the accept cycle
  always_comb begin
    rd_mux = '0;
    if (i_addr == ADDR_CTRL)         rd_mux = {{(32-CTRL_W){1'b0}}, ctrl};
    else if (i_addr == ADDR_COUNT)   rd_mux = count;
    else if (i_addr == ADDR_COMPARE) rd_mux = compare;
    else if (i_addr == ADDR_STATUS)  rd_mux = {30'd0, capf, match};
    else if (i_addr == ADDR_CAPTURE) rd_mux = capture;
  end

  // Response pipeline: ack and read data one cycle after accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= (accept & ~i_we) ? rd_mux : '0;
    end
  end

  // The data/ack nets are shared, so drive them only while the master still holds the cycle
  assign o_wb_ack = ack_q & i_wb_cyc;
  assign o_data   = o_wb_ack ? rdata_q : '0;

  // CTRL, COUNT and COMPARE: tick effects first, bus writes override them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl    <= '0;
      count   <= '0;
      compare <= RESET_COMPARE;
    end else begin
      if (tick) begin
        if (count == compare) begin
          if (ctrl[CTRL_AUTORELOAD]) count <= '0;
          else                       ctrl[CTRL_EN] <= 1'b0;
        end else begin
          count <= count + 32'd1;
        end
      end
      if (wr_ctrl)    ctrl    <= i_data[CTRL_W-1:0];
      if (wr_count)   count   <= i_data;
      if (wr_compare) compare <= i_data;
    end
  end

  // MATCH flag: write-1-to-clear, a new match in the same cycle wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match <= 1'b0;
    end else begin
      if (wr_status && i_data[ST_MATCH]) match <= 1'b0;
      if (hit)                           match <= 1'b1;
    end
  end

`ifdef WB_TIMER_CAPTURE_EN
  logic [2:0] cap_sync;
  logic       cap_rise;

  // Two synchronizer flops plus one history flop for rising-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cap_sync <= '0;
    else        cap_sync <= {cap_sync[1:0], i_capture};
  end

  assign cap_rise = cap_sync[1] & ~cap_sync[2];

  // Latch COUNT on a capture edge and raise CAPF; a fresh capture beats a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      capture <= '0;
      capf    <= 1'b0;
    end else begin
      if (cap_rise) capture <= count;
      if (wr_status && i_data[ST_CAPF]) capf <= 1'b0;
      if (cap_rise) capf <= 1'b1;
    end
  end
`else
  assign capture = '0;
  assign capf    = 1'b0;
`endif

  // Level interrupt, registered one cycle behind the status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= (match | capf) & ctrl[CTRL_IRQEN];
  end

  assign o_irq = irq_q;

endmodule
